// File: rtl/lcu_if.sv
// Bus between an adder datapath and the lookahead carry unit: per-bit
// propagate/generate and carry-in toward the LCU, carries and group P/G back.
interface lcu_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             cin;
  logic [WIDTH-1:0] c;
  logic             PP;
  logic             GG;

  modport master (output p, g, cin, input  c, PP, GG);
  modport slave  (input  p, g, cin, output c, PP, GG);
endinterface

// File: rtl/lcu.sv
// Registered lookahead carry unit: a 4-ary tree of 4-bit lookahead cells,
// combinational from input sample to output registers, one-cycle latency.
module lcu #(
  parameter int WIDTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  lcu_if.slave  bus
);

  localparam int LEVELS = (WIDTH <= 4) ? 1 : (WIDTH <= 16) ? 2 : 3;
  // Every tree node at level >= 1, flattened level by level; root is last.
  localparam int NODES  = (WIDTH - 1) / 3;

  if (!(WIDTH == 4 || WIDTH == 16 || WIDTH == 64)) begin : g_bad_width
    $error("lcu: WIDTH must be 4, 16 or 64");
  end

  function automatic int lvl_off(input int k);
    int off;
    off = 0;
    for (int i = 1; i < k; i++) off += WIDTH >> (2 * i);
    return off;
  endfunction

  // Returns {PP, GG} of a 4-wide group.
  function automatic logic [1:0] group_pg(input logic [3:0] pp, input logic [3:0] gg);
    logic grp_gen;
    grp_gen = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
            | (pp[3] & pp[2] & pp[1] & gg[0]);
    return {&pp, grp_gen};
  endfunction

  // Lookahead carries out of positions 0..2 of a 4-wide group.
  function automatic logic [2:0] carry3(input logic [2:0] pp, input logic [2:0] gg,
                                        input logic ci);
    logic [2:0] co;
    co[0] = gg[0] | (pp[0] & ci);
    co[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    co[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
          | (pp[2] & pp[1] & pp[0] & ci);
    return co;
  endfunction

  logic [NODES-1:0] grp_p;
  logic [NODES-1:0] grp_g;
  logic [NODES-1:0] grp_ci;
  logic [WIDTH-1:0] c_d, c_q;
  logic             pp_d, pp_q;
  logic             gg_d, gg_q;

  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves one
    // unassigned; otherwise a latch is inferred.
    grp_p  = '0;
    grp_g  = '0;
    grp_ci = '0;
    c_d    = '0;

    // Bottom-up: group propagate/generate at every tree level.
    for (int k = 1; k <= LEVELS; k++) begin
      for (int j = 0; j < (WIDTH >> (2 * k)); j++) begin
        if (k == 1) begin
          {grp_p[j], grp_g[j]} = group_pg(bus.p[4*j +: 4], bus.g[4*j +: 4]);
        end else begin
          {grp_p[lvl_off(k) + j], grp_g[lvl_off(k) + j]} =
            group_pg(grp_p[lvl_off(k-1) + 4*j +: 4], grp_g[lvl_off(k-1) + 4*j +: 4]);
        end
      end
    end

    // Top-down: each upper cell hands carry-ins to its four children.
    grp_ci[NODES-1] = bus.cin;
    for (int k = LEVELS; k >= 2; k--) begin
      for (int j = 0; j < (WIDTH >> (2 * k)); j++) begin
        grp_ci[lvl_off(k-1) + 4*j] = grp_ci[lvl_off(k) + j];
        grp_ci[lvl_off(k-1) + 4*j + 1 +: 3] =
          carry3(grp_p[lvl_off(k-1) + 4*j +: 3], grp_g[lvl_off(k-1) + 4*j +: 3],
                 grp_ci[lvl_off(k) + j]);
      end
    end

    // Leaf cells: bit carries; the top bit reuses the leaf's own group P/G.
    for (int j = 0; j < (WIDTH >> 2); j++) begin
      c_d[4*j +: 3] = carry3(bus.p[4*j +: 3], bus.g[4*j +: 3], grp_ci[j]);
      c_d[4*j + 3]  = grp_g[j] | (grp_p[j] & grp_ci[j]);
    end

    pp_d = grp_p[NODES-1];
    gg_d = grp_g[NODES-1];
  end

  // NOTE: registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q  <= '0;
      pp_q <= 1'b0;
      gg_q <= 1'b0;
    end else begin
      c_q  <= c_d;
      pp_q <= pp_d;
      gg_q <= gg_d;
    end
  end

  assign bus.c  = c_q;
  assign bus.PP = pp_q;
  assign bus.GG = gg_q;

endmodule

// File: tb/tb_lcu.sv
// Self-checking bench for lcu at WIDTH=4 and WIDTH=16 side by side, using a
// ripple-recurrence reference model and a one-deep scoreboard per instance.
module tb_lcu;

  typedef struct {
    logic [15:0] c;
    logic        pp;
    logic        gg;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_rand;
  exp_t q4[$];
  exp_t q16[$];

  lcu_if #(.WIDTH(4))  if4 ();
  lcu_if #(.WIDTH(16)) if16 ();

  lcu #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
  lcu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain ripple recurrence over the low w bits.
  function automatic exp_t model(input logic [15:0] p, input logic [15:0] g,
                                 input logic ci, input int w);
    exp_t e;
    logic carry;
    e.c   = '0;
    e.pp  = 1'b1;
    carry = ci;
    for (int i = 0; i < w; i++) begin
      carry  = g[i] | (p[i] & carry);
      e.c[i] = carry;
      e.pp   = e.pp & p[i];
    end
    carry = 1'b0;
    for (int i = 0; i < w; i++) carry = g[i] | (p[i] & carry);
    e.gg = carry;
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input int w);
    exp_t e;
    if ((w == 4 && q4.size() == 0) || (w == 16 && q16.size() == 0)) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty (observed none, expected one entry)", tag);
    end else if (w == 4) begin
      e = q4.pop_front();
      check({tag, ".c4"},  {12'h000, if4.c}, e.c);
      check({tag, ".PP4"}, {15'h0, if4.PP},  {15'h0, e.pp});
      check({tag, ".GG4"}, {15'h0, if4.GG},  {15'h0, e.gg});
    end else begin
      e = q16.pop_front();
      check({tag, ".c16"},  if16.c,           e.c);
      check({tag, ".PP16"}, {15'h0, if16.PP}, {15'h0, e.pp});
      check({tag, ".GG16"}, {15'h0, if16.GG}, {15'h0, e.gg});
    end
  endtask

  // One cycle: drive both instances at the falling edge, push expectations,
  // then compare just after the next rising edge.
  task automatic step(input string tag, input logic r,
                      input logic [3:0] p4, input logic [3:0] g4, input logic ci4,
                      input logic [15:0] p16, input logic [15:0] g16, input logic ci16);
    exp_t zero;
    zero = '{c: 16'h0000, pp: 1'b0, gg: 1'b0};
    @(negedge clk);
    rst      = r;
    if4.p    = p4;
    if4.g    = g4;
    if4.cin  = ci4;
    if16.p   = p16;
    if16.g   = g16;
    if16.cin = ci16;
    q4.push_back(r ? zero : model({12'h000, p4}, {12'h000, g4}, ci4, 4));
    q16.push_back(r ? zero : model(p16, g16, ci16, 16));
    @(posedge clk);
    #1;
    pop_check(tag, 4);
    pop_check(tag, 16);
  endtask

  initial begin
    logic [15:0] rp;
    logic [15:0] rg;
    logic        rc;
    logic [3:0]  sp;
    logic [3:0]  sg;
    n_checks = 0;
    n_fail   = 0;
    n_rand   = 0;
    rst      = 1'b1;
    if4.p    = '0;
    if4.g    = '0;
    if4.cin  = 1'b0;
    if16.p   = '0;
    if16.g   = '0;
    if16.cin = 1'b0;

    // Reset dominates all-ones inputs, then release.
    step("rst0",    1'b1, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step("rst1",    1'b1, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step("rel",     1'b0, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);

    // Directed boundary cases.
    step("prop_c1", 1'b0, 4'hF, 4'h0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    step("prop_c0", 1'b0, 4'hF, 4'h0, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    step("gen_chn", 1'b0, 4'hE, 4'h1, 1'b0, 16'hFFFE, 16'h0001, 1'b0);
    step("kill_lo", 1'b0, 4'h0, 4'h1, 1'b1, 16'h0000, 16'h0001, 1'b1);
    step("kill_hi", 1'b0, 4'h0, 4'h8, 1'b0, 16'h0000, 16'h8000, 1'b0);
    step("p_and_g", 1'b0, 4'hF, 4'hF, 1'b0, 16'h0F0F, 16'hFFFF, 1'b0);

    // Exhaustive 4-bit sweep with a reset pulse mid-way; 16-bit gets random.
    for (int ci = 0; ci < 2; ci++) begin
      for (int pg = 0; pg < 256; pg++) begin
        sp = 4'(pg >> 4);
        sg = 4'(pg);
        rp = 16'($urandom_range(65535));
        rg = 16'($urandom_range(65535));
        rc = 1'($urandom_range(1));
        if (ci == 1 && pg == 100) begin
          step("mid_rst", 1'b1, sp, sg, 1'(ci), rp, rg, rc);
        end
        step("sweep", 1'b0, sp, sg, 1'(ci), rp, rg, rc);
        n_rand++;
      end
    end

    // Remaining random vectors for both widths.
    while (n_rand < 10000) begin
      rp = 16'($urandom_range(65535));
      rg = 16'($urandom_range(65535));
      rc = 1'($urandom_range(1));
      step("rand", 1'b0, rp[3:0], rg[3:0], rc, rp, rg, rc);
      n_rand++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
